// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receiver with configurable length, parity, stop bits and per-frame errors.
// Define RX_MAJORITY_VOTE_EN for a 2-of-3 vote around mid-bit instead of a single mid-bit sample.
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 clken,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] MID = CW'(OVERSAMPLE / 2 + 1);
`else
    localparam logic [CW-1:0] MID = CW'(OVERSAMPLE / 2);
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state_q, state_d;
    logic                 rx_m_q, rx_s_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] scratch_q, scratch_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 stop_q, stop_d;
    logic                 rdy_q, rdy_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 sample;
    logic                 done;

`ifdef RX_MAJORITY_VOTE_EN
    logic v0_q, v1_q;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            v0_q <= 1'b1;
            v1_q <= 1'b1;
        end else if (clken) begin
            if (cnt_q == CW'(OVERSAMPLE / 2 - 1)) v0_q <= rx_s_q;
            if (cnt_q == CW'(OVERSAMPLE / 2)) v1_q <= rx_s_q;
        end
    end

    assign sample = (v0_q & v1_q) | (v0_q & rx_s_q) | (v1_q & rx_s_q);
`else
    assign sample = rx_s_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        scratch_d = scratch_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        stop_d    = stop_q;
        done      = 1'b0;
        if (clken) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    cnt_d = rx_s_q ? '0 : CW'(1);
                    if (!rx_s_q) begin
                        state_d = S_START;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        stop_d  = 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_q == MID && sample) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end
                S_DATA: begin
                    for (int i = 0; i < DATA_BITS; i++)
                        if (cnt_q == MID && bit_q == BW'(i)) scratch_d[i] = sample;
                    if (cnt_q == LAST) begin
                        bit_d = bit_q + 1'b1;
                        if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    if (cnt_q == MID) perr_d = ^scratch_q ^ sample ^ (PARITY == 1);
                    if (cnt_q == LAST) state_d = S_STOP;
                end
                S_STOP: begin
                    // completing at mid-bit leaves half a bit to catch an early next start
                    if (cnt_q == MID) begin
                        ferr_d = ferr_q | !sample;
                        if (stop_q == 1'(STOP_BITS - 1)) begin
                            done    = 1'b1;
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end
                    if (cnt_q == LAST) stop_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
        rdy_d        = done | (rdy_q & !rdy_clr);
        overrun_d    = !rdy_clr & (overrun_q | (done & rdy_q));
        data_d       = done ? scratch_q : data_q;
        parity_err_d = done ? perr_q : parity_err_q;
        frame_err_d  = done ? ferr_d : frame_err_q;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_m_q       <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            scratch_q    <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            stop_q       <= 1'b0;
            rdy_q        <= 1'b0;
            data_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_m_q       <= rx;
            rx_s_q       <= rx_m_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            scratch_q    <= scratch_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            stop_q       <= stop_d;
            rdy_q        <= rdy_d;
            data_q       <= data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rdy        = rdy_q;
    assign data       = data_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: frames into an 8N1 and a 7E2 receiver, checked every cycle against a frame-level model.
module tb_uart_rx_frame;
    localparam int OS = 16;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int SAMP = OS / 2 + 1;
    localparam bit VOTE = 1'b1;
`else
    localparam int SAMP = OS / 2;
    localparam bit VOTE = 1'b0;
`endif

    typedef struct {
        int         u;
        int         done;
        logic [8:0] d;
        bit         pe;
        bit         fe;
    } exp_t;

    logic       clk, rst_n, clken, rdy_clr, rx0, rx1;
    logic       rdy0, pe0, fe0, ov0, rdy1, pe1, fe1, ov1;
    logic [7:0] data0;
    logic [6:0] data1;

    exp_t       q[$];
    int         tick = 0;
    int         n_chk = 0, n_fail = 0;
    int         clr_cnt = 0, clr_done = 0, clr_tick = 0, ph = 0;
    bit         rand_clr = 1'b0, hit;
    logic       m_rdy[2] = '{1'b0, 1'b0};
    logic       m_pe[2] = '{1'b0, 1'b0};
    logic       m_fe[2] = '{1'b0, 1'b0};
    logic       m_ov[2] = '{1'b0, 1'b0};
    logic [8:0] m_data[2] = '{9'd0, 9'd0};

    uart_rx_frame u0 (
        .clk_50m(clk), .rst_n(rst_n), .clken(clken), .rx(rx0), .rdy_clr(rdy_clr),
        .rdy(rdy0), .data(data0), .parity_err(pe0), .frame_err(fe0), .overrun(ov0)
    );

    uart_rx_frame #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk_50m(clk), .rst_n(rst_n), .clken(clken), .rx(rx1), .rdy_clr(rdy_clr),
        .rdy(rdy1), .data(data1), .parity_err(pe1), .frame_err(fe1), .overrun(ov1)
    );

    function automatic int db(int u);
        return (u != 0) ? 7 : 8;
    endfunction

    function automatic int par(int u);
        return (u != 0) ? 2 : 0;
    endfunction

    function automatic int sb(int u);
        return (u != 0) ? 2 : 1;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // clken every 4th cycle; rdy_clr pulses on request, on a chosen tick, or randomly
    initial begin
        clken = 1'b0;
        rdy_clr = 1'b0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            clken = (ph == 0);
            rdy_clr = (clr_cnt != clr_done) || (clken && tick + 1 == clr_tick) ||
                      (rand_clr && $urandom_range(0, 63) == 0);
            clr_done = clr_cnt;
        end
    end

    // frame-level model: a frame's result lands on its scheduled completion tick
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 2; i++) begin
                m_rdy[i] = 1'b0;
                m_pe[i] = 1'b0;
                m_fe[i] = 1'b0;
                m_ov[i] = 1'b0;
                m_data[i] = '0;
            end
        end else begin
            if (clken) tick++;
            for (int i = 0; i < 2; i++) begin
                hit = clken && q.size() > 0 && q[0].u == i && q[0].done == tick;
                m_ov[i] = rdy_clr ? 1'b0 : (m_ov[i] | (hit & m_rdy[i]));
                m_rdy[i] = hit | (m_rdy[i] & !rdy_clr);
                if (hit) begin
                    m_data[i] = q[0].d;
                    m_pe[i] = q[0].pe;
                    m_fe[i] = q[0].fe;
                    void'(q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("rdy0", rdy0, m_rdy[0]);
        chk("data0", data0, m_data[0][7:0]);
        chk("parity_err0", pe0, m_pe[0]);
        chk("frame_err0", fe0, m_fe[0]);
        chk("overrun0", ov0, m_ov[0]);
        chk("rdy1", rdy1, m_rdy[1]);
        chk("data1", data1, m_data[1][6:0]);
        chk("parity_err1", pe1, m_pe[1]);
        chk("frame_err1", fe1, m_fe[1]);
        chk("overrun1", ov1, m_ov[1]);
    end

    task automatic drive(int u, logic v, int n);
        if (u == 0) rx0 = v;
        else rx1 = v;
        repeat (n) @(posedge clk iff clken);
        @(negedge clk);
    endtask

    task automatic sync_tick();
        @(posedge clk iff clken);
        @(negedge clk);
    endtask

    task automatic send(int u, int d, bit bad_par, int stop_low, int gap, bit clr_at_done, bit inv);
        int         nb;
        logic [8:0] dv;
        exp_t       e;
        logic       lv[$];
        sync_tick();
        dv = 9'(d) & 9'((1 << db(u)) - 1);
        nb = 1 + db(u) + ((par(u) != 0) ? 1 : 0) + sb(u);
        e.u = u;
        e.done = tick + 1 + (nb - 1) * OS + SAMP;
        e.d = dv;
        e.pe = (par(u) != 0) && bad_par;
        e.fe = (stop_low & ((1 << sb(u)) - 1)) != 0;
        q.push_back(e);
        if (clr_at_done) clr_tick = e.done;
        lv.push_back(1'b0);
        for (int i = 0; i < db(u); i++) lv.push_back(dv[i]);
        if (par(u) != 0) lv.push_back((^dv) ^ (par(u) == 1) ^ bad_par);
        for (int s = 0; s < sb(u); s++) lv.push_back(!stop_low[s]);
        foreach (lv[i]) begin
            if (inv) begin
                drive(u, lv[i], OS / 2);
                drive(u, !lv[i], 1);
                drive(u, lv[i], OS / 2 - 1);
            end else drive(u, lv[i], OS);
        end
        drive(u, 1'b1, gap);
    endtask

    task automatic pulse_clr();
        clr_cnt++;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int sl;
        rst_n = 1'b0;
        rx0 = 1'b1;
        rx1 = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rdy", rdy0, 0);
        chk("reset_data", data0, 0);
        chk("reset_perr", pe0, 0);
        chk("reset_ferr", fe0, 0);
        chk("reset_ovr", ov0, 0);

        send(0, 'hA5, 0, 0, 8, 0, VOTE);
        chk("a5_rdy", rdy0, 1);
        chk("a5_data", data0, 'hA5);
        chk("a5_perr", pe0, 0);
        chk("a5_ferr", fe0, 0);
        chk("a5_ovr", ov0, 0);
        pulse_clr();
        chk("a5_clr_rdy", rdy0, 0);

        sync_tick();
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 20);
        chk("glitch_rdy", rdy0, 0);
        send(0, 'h3C, 0, 0, 8, 0, VOTE);
        chk("3c_data", data0, 'h3C);
        pulse_clr();

        send(1, 'h55, 0, 0, 8, 0, VOTE);
        chk("7e2_good_data", data1, 'h55);
        chk("7e2_good_perr", pe1, 0);
        send(1, 'h55, 1, 0, 8, 0, VOTE);
        chk("7e2_bad_data", data1, 'h55);
        chk("7e2_bad_perr", pe1, 1);
        chk("7e2_bad_ovr", ov1, 1);
        pulse_clr();

        send(0, 'h81, 0, 1, 8, 0, VOTE);
        chk("81_ferr", fe0, 1);
        chk("81_data", data0, 'h81);
        pulse_clr();

        send(0, 'h11, 0, 0, 0, 0, VOTE);
        send(0, 'h22, 0, 0, 8, 0, VOTE);
        chk("ovr_data", data0, 'h22);
        chk("ovr_set", ov0, 1);
        send(0, 'h33, 0, 0, 8, 1, VOTE);
        chk("clr_on_done_rdy", rdy0, 1);
        chk("clr_on_done_ovr", ov0, 0);

        sync_tick();
        drive(0, 1'b0, OS);
        for (int i = 0; i < 4; i++) drive(0, 1'b1, OS);
        drive(0, 1'b1, OS / 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        rx0 = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rdy", rdy0, 0);
        chk("midrst_data", data0, 0);
        chk("midrst_ferr", fe0, 0);
        chk("midrst_ovr", ov0, 0);
        chk("midrst_data1", data1, 0);
        repeat (OS) sync_tick();
        send(0, 'hF0, 0, 0, 8, 0, VOTE);
        chk("f0_data", data0, 'hF0);

        send(0, 'h00, 0, 1, 8, 0, VOTE);
        chk("break_data", data0, 0);
        chk("break_ferr", fe0, 1);

        rand_clr = 1'b1;
        repeat (30) begin
            sl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            send($urandom_range(0, 1), $urandom_range(0, 511), $urandom_range(0, 1), sl,
                 (sl != 0) ? $urandom_range(4, 16) : $urandom_range(0, 16), 0,
                 VOTE && ($urandom_range(0, 1) == 1));
        end
        rand_clr = 1'b0;
        repeat (OS) sync_tick();
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end
endmodule
